// File: rtl/stage_c_execute.sv
// -----------------------------------------------------------------------------
// stage_c_execute -- execute stage of the bfcpu2 pipeline (feeds writeback).
//
// Takes a decoded operation, its data pointer and the operand cell fetched by
// the memory-read stage. It computes the new cell value (increment, decrement,
// pass-through or console input), drives the console I/O handshakes, and hands
// {operation, dp, dq} to writeback through a single registered valid/ack slice.
// The stage stalls on console I/O and on downstream back-pressure.
//
// Optional feature macro: STAGE_C_FORWARD_EN
//   defined   : a result still in the output slot is forwarded as the operand
//               when the next op targets the same cell, so there is no stall.
//   undefined : an op targeting the cell held in the output slot is stalled
//               (ack=0) until that result drains to writeback.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   operation_in  in   decoded op from memory-read stage
//   dp_in         in   data pointer belonging to operation_in
//   data_in       in   cell value at dp_in
//   drdy_in       in   upstream valid
//   ack           out  upstream accept (combinational)
//   operation     out  op to writeback (registered)
//   dp            out  pointer to writeback (registered)
//   dq            out  result cell value (registered)
//   drdy          out  downstream valid (registered)
//   ack_in        in   downstream accept
//   in_data       in   console input byte
//   in_valid      in   console input available
//   in_ack        out  one-cycle pulse: in_data consumed (registered)
//   out_data      out  console output byte (registered)
//   out_valid     out  console output pending (registered)
//   out_ack       in   console accepted out_data
// -----------------------------------------------------------------------------

// Opcode encoding shared with the rest of the bfcpu2 pipeline. Guarded so a
// project-wide definition takes precedence.
`ifndef OPCODE_MSB
  `define OPCODE_MSB 3
`endif
`ifndef OP_NOP
  `define OP_NOP  4'd0
`endif
`ifndef OP_INC
  `define OP_INC  4'd1
`endif
`ifndef OP_DEC
  `define OP_DEC  4'd2
`endif
`ifndef OP_PINC
  `define OP_PINC 4'd3
`endif
`ifndef OP_PDEC
  `define OP_PDEC 4'd4
`endif
`ifndef OP_IN
  `define OP_IN   4'd5
`endif
`ifndef OP_OUT
  `define OP_OUT  4'd6
`endif
`ifndef OP_JZ
  `define OP_JZ   4'd7
`endif
`ifndef OP_JNZ
  `define OP_JNZ  4'd8
`endif

module stage_c_execute #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  // upstream (memory-read stage)
  input  logic [`OPCODE_MSB:0] operation_in,
  input  logic [A_WIDTH-1:0]   dp_in,
  input  logic [D_WIDTH-1:0]   data_in,
  input  logic                 drdy_in,
  output logic                 ack,
  // downstream (writeback stage)
  output logic [`OPCODE_MSB:0] operation,
  output logic [A_WIDTH-1:0]   dp,
  output logic [D_WIDTH-1:0]   dq,
  output logic                 drdy,
  input  logic                 ack_in,
  // console input
  input  logic [D_WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ack,
  // console output
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ack
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  state_t             state;
  logic [D_WIDTH-1:0] operand;
  logic               hazard;
  logic               up_xfer;
  logic               dn_xfer;

  // NOTE: every signal driven in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    operand = data_in;
    hazard  = 1'b0;
`ifdef STAGE_C_FORWARD_EN
    // The slot still holds the newest value of this cell; writeback has not
    // stored it yet, so memory-read handed us a stale copy.
    if (drdy && (dp_in == dp)) operand = dq;
`else
    hazard = drdy && (dp_in == dp);
`endif
    // Accept only when the slot is free or draining this edge; this also
    // guarantees the slot is empty on entry to the I/O wait states.
    ack = (state == RUN) && (!drdy || ack_in) && !hazard;
  end

  assign up_xfer = drdy_in && ack;
  assign dn_xfer = drdy && ack_in;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      operation <= '0;
      dp        <= '0;
      dq        <= '0;
      drdy      <= 1'b0;
      in_ack    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      in_ack <= 1'b0;  // pulse: only set on the capture edge below
      case (state)
        RUN: begin
          if (up_xfer) begin
            operation <= operation_in;
            dp        <= dp_in;
            case (operation_in)
              `OP_INC: begin
                dq   <= operand + 1'b1;
                drdy <= 1'b1;
              end
              `OP_DEC: begin
                dq   <= operand - 1'b1;
                drdy <= 1'b1;
              end
              `OP_IN: begin
                drdy  <= 1'b0;
                state <= WAIT_IN;
              end
              `OP_OUT: begin
                // out_data doubles as the saved operand for the later dq load.
                out_data  <= operand;
                out_valid <= 1'b1;
                drdy      <= 1'b0;
                state     <= WAIT_OUT;
              end
              default: begin
                dq   <= operand;
                drdy <= 1'b1;
              end
            endcase
          end else if (dn_xfer) begin
            drdy <= 1'b0;
          end
        end

        WAIT_IN: begin
          if (in_valid) begin
            dq     <= in_data;
            in_ack <= 1'b1;
            drdy   <= 1'b1;
            state  <= RUN;
          end
        end

        WAIT_OUT: begin
          if (out_ack) begin
            out_valid <= 1'b0;
            dq        <= out_data;
            drdy      <= 1'b1;
            state     <= RUN;
          end
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_c_execute.sv
// -----------------------------------------------------------------------------
// tb_stage_c_execute -- self-checking bench for stage_c_execute.
// Directed stimulus pushes the expected writeback record into a scoreboard
// queue; an independent monitor pops and compares on every downstream transfer.
// Handshake and stability properties are checked inline with check().
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stage_c_execute;

  localparam int A_W = 12;
  localparam int D_W = 8;

  // Opcode values written out by hand, independent of the RTL's macros.
  localparam logic [3:0] T_NOP = 4'd0;
  localparam logic [3:0] T_INC = 4'd1;
  localparam logic [3:0] T_DEC = 4'd2;
  localparam logic [3:0] T_IN  = 4'd5;
  localparam logic [3:0] T_OUT = 4'd6;

  typedef struct packed {
    logic [3:0]     op;
    logic [A_W-1:0] dp;
    logic [D_W-1:0] dq;
  } wb_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     operation_in = '0;
  logic [A_W-1:0] dp_in = '0;
  logic [D_W-1:0] data_in = '0;
  logic           drdy_in = 1'b0;
  logic           ack;
  logic [3:0]     operation;
  logic [A_W-1:0] dp;
  logic [D_W-1:0] dq;
  logic           drdy;
  logic           ack_in = 1'b1;
  logic [D_W-1:0] in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ack;
  logic [D_W-1:0] out_data;
  logic           out_valid;
  logic           out_ack = 1'b0;

  int  tests_run = 0;
  int  tests_failed = 0;
  wb_t sb[$];

  always #5 clk = ~clk;

  stage_c_execute #(.A_WIDTH(A_W), .D_WIDTH(D_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .operation_in (operation_in),
    .dp_in        (dp_in),
    .data_in      (data_in),
    .drdy_in      (drdy_in),
    .ack          (ack),
    .operation    (operation),
    .dp           (dp),
    .dq           (dq),
    .drdy         (drdy),
    .ack_in       (ack_in),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ack       (in_ack),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ack      (out_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change only at posedge+1; sampling on the falling edge sees a
  // stable drdy/ack_in pair that the next rising edge will act on.
  always @(negedge clk) begin
    if (reset && drdy && ack_in) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", {operation, dp, dq}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("sb_operation", 32'(operation), 32'(e.op));
        check("sb_dp",        32'(dp),        32'(e.dp));
        check("sb_dq",        32'(dq),        32'(e.dq));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait (bounded) for ack, let it transfer, drop drdy_in.
  task automatic issue(input logic [3:0] op, input logic [A_W-1:0] p, input logic [D_W-1:0] d);
    int n;
    n = 0;
    operation_in = op;
    dp_in        = p;
    data_in      = d;
    drdy_in      = 1'b1;
    #1;
    while (!ack && n < 50) begin
      tick();
      n++;
    end
    if (!ack) check("issue_ack_timeout", 32'(ack), 32'd1);
    tick();
    drdy_in = 1'b0;
  endtask

  function automatic wb_t rec(input logic [3:0] op, input logic [A_W-1:0] p, input logic [D_W-1:0] d);
    wb_t r;
    r.op = op;
    r.dp = p;
    r.dq = d;
    return r;
  endfunction

  initial begin
    logic [3:0]     h_op;
    logic [A_W-1:0] h_dp;
    logic [D_W-1:0] h_dq;
    int n;

    // ---- reset state ----
    repeat (2) tick();
    check("rst_drdy", 32'(drdy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    tick();
    #1;
    check("post_rst_ack", 32'(ack), 32'd1);

    // ---- INC wrap, then DEC wrap ----
    sb.push_back(rec(T_INC, 12'd5, 8'h00));
    issue(T_INC, 12'd5, 8'hFF);
    check("inc_drdy", 32'(drdy), 32'd1);
    check("inc_dq",   32'(dq),   32'h00);
    check("inc_dp",   32'(dp),   32'd5);
    sb.push_back(rec(T_DEC, 12'd6, 8'hFF));
    issue(T_DEC, 12'd6, 8'h00);
    check("dec_dq", 32'(dq), 32'hFF);
    tick();

    // ---- back-pressure: hold, then drain + accept on one edge ----
    ack_in = 1'b0;
    sb.push_back(rec(T_INC, 12'd7, 8'h21));
    issue(T_INC, 12'd7, 8'h20);
    operation_in = T_DEC;
    dp_in        = 12'd8;
    data_in      = 8'h30;
    drdy_in      = 1'b1;
    #1;
    check("bp_ack_low", 32'(ack), 32'd0);
    h_op = operation;
    h_dp = dp;
    h_dq = dq;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold", {8'(drdy), 4'(operation), 12'(dp), 8'(dq)}, {8'd1, h_op, h_dp, h_dq});
    end
    ack_in = 1'b1;
    #1;
    check("bp_ack_release", 32'(ack), 32'd1);
    sb.push_back(rec(T_DEC, 12'd8, 8'h2F));
    tick();
    drdy_in = 1'b0;
    check("bp_new_loaded", {8'(drdy), 8'(dq)}, {8'd1, 8'h2F});
    tick();

    // ---- console input ----
    sb.push_back(rec(T_IN, 12'd9, 8'h41));
    issue(T_IN, 12'd9, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("in_wait_drdy", 32'(drdy), 32'd0);
      check("in_wait_ack",  32'(ack),  32'd0);
      tick();
    end
    in_data  = 8'h41;
    in_valid = 1'b1;
    tick();
    check("in_ack_pulse", 32'(in_ack), 32'd1);
    check("in_dq", {8'(drdy), 8'(dq)}, {8'd1, 8'h41});
    tick();
    in_valid = 1'b0;
    check("in_ack_single", 32'(in_ack), 32'd0);
    tick();

    // ---- console output ----
    sb.push_back(rec(T_OUT, 12'd11, 8'h7A));
    issue(T_OUT, 12'd11, 8'h7A);
    data_in = 8'h00;
    for (int i = 0; i < 2; i++) begin
      check("out_pending", {8'(out_valid), 8'(out_data)}, {8'd1, 8'h7A});
      check("out_wait_ack", {8'(ack), 8'(drdy)}, {8'd0, 8'd0});
      tick();
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    check("out_done", {8'(out_valid), 8'(drdy), 8'(dq)}, {8'd0, 8'd1, 8'h7A});
    tick();

    // ---- reset while waiting on console output ----
    issue(T_OUT, 12'd12, 8'h55);
    check("rst_pre_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_outputs",
          {4'(operation), 12'(dp), 8'(dq), 8'(out_data)}, 32'd0);
    check("rst_async_flags", {8'(drdy), 8'(in_ack), 8'(out_valid)}, 24'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_release_ack", {8'(ack), 8'(out_valid)}, {8'd1, 8'd0});

    // ---- back-to-back INC on the same cell ----
    ack_in = 1'b0;
    sb.push_back(rec(T_INC, 12'd3, 8'h11));
    issue(T_INC, 12'd3, 8'h10);
    operation_in = T_INC;
    dp_in        = 12'd3;
    data_in      = 8'h10;
    drdy_in      = 1'b1;
    #1;
    check("b2b_ack_stalled", 32'(ack), 32'd0);
    tick();
    ack_in = 1'b1;
    #1;
`ifdef STAGE_C_FORWARD_EN
    check("b2b_fwd_ack", 32'(ack), 32'd1);
    sb.push_back(rec(T_INC, 12'd3, 8'h12));
`else
    check("b2b_hazard_ack", 32'(ack), 32'd0);
    sb.push_back(rec(T_INC, 12'd3, 8'h11));
`endif
    n = 0;
    while (!ack && n < 50) begin
      tick();
      n++;
    end
    if (!ack) check("b2b_ack_timeout", 32'(ack), 32'd1);
    tick();
    drdy_in = 1'b0;
`ifdef STAGE_C_FORWARD_EN
    check("b2b_dq", 32'(dq), 32'h12);
`else
    check("b2b_dq", 32'(dq), 32'h11);
`endif

    // ---- drain and final scoreboard check ----
    repeat (4) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("idle_drdy", 32'(drdy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
